// File: rtl/audio_pkg.sv
// Shared audio constants: FSM encoding, clock rate, default amplitude and
// note divisors, so the decoder, tone generator and benches agree.
package audio_pkg;

  typedef enum logic {
    SILENT = 1'b0,
    RUN    = 1'b1
  } tone_state_e;

  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned DIV_W_DEF    = 32;
  localparam int unsigned SAMPLE_W_DEF = 16;

  localparam logic signed [15:0] DEFAULT_AMPLITUDE = 16'sh2000;

  // Full-period divisors for one octave starting at C5.
  localparam int unsigned DO1 = CLK_HZ / 523;
  localparam int unsigned RE  = CLK_HZ / 587;
  localparam int unsigned MI  = CLK_HZ / 659;
  localparam int unsigned FA  = CLK_HZ / 698;
  localparam int unsigned SO  = CLK_HZ / 784;
  localparam int unsigned LA  = CLK_HZ / 880;
  localparam int unsigned SI  = CLK_HZ / 988;
  localparam int unsigned DO2 = CLK_HZ / 1046;

endpackage

// File: rtl/half_period_counter.sv
// Half-period timer: counts cycles of the active half period, reloads the
// half length only at a wrap, and pulses half_tick alongside each toggle.
module half_period_counter #(
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_half,
  output logic             o_wrap_c,
  output logic             o_half_tick
);

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] r_active_half;
  logic             r_half_tick;

  assign o_wrap_c    = i_run && (r_count == (r_active_half - DIV_W'(1)));
  assign o_half_tick = r_half_tick;

  // The new half length is sampled only at load or wrap, never mid half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count       <= DIV_W'(0);
      r_active_half <= DIV_W'(0);
      r_half_tick   <= 1'b0;
    end else begin
      r_half_tick <= 1'b0;
      if (i_load) begin
        r_count       <= DIV_W'(0);
        r_active_half <= i_half;
      end else if (o_wrap_c) begin
        r_count       <= DIV_W'(0);
        r_active_half <= i_half;
        r_half_tick   <= 1'b1;
      end else if (i_run) begin
        r_count <= r_count + DIV_W'(1);
      end else begin
        r_count <= DIV_W'(0);
      end
    end
  end

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator with glitch-free pitch changes and a
// request/valid PCM sample port for the audio codec.
module tone_gen
  import audio_pkg::*;
#(
  parameter int unsigned                DIV_W     = DIV_W_DEF,
  parameter int unsigned                SAMPLE_W  = SAMPLE_W_DEF,
  parameter logic signed [SAMPLE_W-1:0] AMPLITUDE = SAMPLE_W'(DEFAULT_AMPLITUDE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DIV_W-1:0]           divisor,
  input  logic                       enable,
  input  logic                       sample_req,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic                       square_out,
  output logic                       half_tick
);

  tone_state_e                r_state;
  tone_state_e                w_state_nxt;
  logic                       r_square;
  logic                       w_square_nxt;
  logic signed [SAMPLE_W-1:0] r_sample;
  logic signed [SAMPLE_W-1:0] w_sample_nxt;
  logic                       r_valid;
  logic                       w_valid_nxt;

  logic             w_go;
  logic             w_load;
  logic             w_run;
  logic             w_wrap;
  logic [DIV_W-1:0] w_half;

  assign w_go   = enable && (divisor >= DIV_W'(2));
  assign w_half = divisor >> 1;
  assign w_load = (r_state == SILENT) && w_go;
  assign w_run  = (r_state == RUN) && w_go;

  half_period_counter #(
    .DIV_W (DIV_W)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_run       (w_run),
    .i_half      (w_half),
    .o_wrap_c    (w_wrap),
    .o_half_tick (half_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= SILENT;
      r_square <= 1'b0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_square <= w_square_nxt;
      r_sample <= w_sample_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  // Samples reflect the state and level present in the request cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_square_nxt = r_square;
    w_sample_nxt = r_sample;
    w_valid_nxt  = 1'b0;

    case (r_state)
      SILENT: begin
        w_square_nxt = 1'b0;
        if (w_go) begin
          w_state_nxt  = RUN;
          w_square_nxt = 1'b1;
        end
      end
      RUN: begin
        if (!w_go) begin
          w_state_nxt  = SILENT;
          w_square_nxt = 1'b0;
        end else if (w_wrap) begin
          w_square_nxt = ~r_square;
        end
      end
      default: begin
        w_state_nxt  = SILENT;
        w_square_nxt = 1'b0;
      end
    endcase

    if (sample_req) begin
      w_valid_nxt = 1'b1;
      if (r_state == RUN) begin
        w_sample_nxt = r_square ? AMPLITUDE : -AMPLITUDE;
      end else begin
        w_sample_nxt = '0;
      end
    end
  end

  assign square_out   = r_square;
  assign sample_out   = r_sample;
  assign sample_valid = r_valid;

endmodule

// File: tb/tb_tone_gen.sv
// Scoreboard bench for tone_gen: a cycle-level behavioural model tracks the
// level and remaining half-period length; samples are checked from a queue.
module tb_tone_gen;
  import audio_pkg::*;

  localparam logic [15:0] SAMPLE_HI = 16'h2000;
  localparam logic [15:0] SAMPLE_LO = 16'hE000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [31:0]        divisor = 32'd8;
  logic               enable = 1'b1;
  logic               sample_req = 1'b0;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               square_out;
  logic               half_tick;

  tone_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .divisor      (divisor),
    .enable       (enable),
    .sample_req   (sample_req),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .square_out   (square_out),
    .half_tick    (half_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state as seen after the latest edge, plus the pending next state.
  logic        m_run = 1'b0, m_level = 1'b0, m_tick = 1'b0, m_valid = 1'b0;
  int unsigned m_left = 0;
  logic        n_run, n_level, n_tick, n_valid;
  int unsigned n_left;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural rule set applied to the inputs present before the next edge.
  task automatic model_step();
    logic go;
    go = enable && (divisor >= 32'd2);
    n_run = m_run; n_level = m_level; n_left = m_left; n_tick = 1'b0;
    n_valid = sample_req;
    if (!rst_n) begin
      n_run = 1'b0; n_level = 1'b0; n_left = 0; n_valid = 1'b0;
    end else begin
      if (sample_req)
        exp_q.push_back(m_run ? (m_level ? SAMPLE_HI : SAMPLE_LO) : 16'h0000);
      if (!m_run) begin
        if (go) begin
          n_run = 1'b1; n_level = 1'b1; n_left = divisor / 2;
        end
      end else if (!go) begin
        n_run = 1'b0; n_level = 1'b0;
      end else if (m_left == 1) begin
        n_level = ~m_level; n_left = divisor / 2; n_tick = 1'b1;
      end else begin
        n_left = m_left - 1;
      end
    end
  endtask

  task automatic tick(input logic en, input logic [31:0] div, input logic req);
    enable = en; divisor = div; sample_req = req;
    model_step();
    @(posedge clk); #1;
    m_run = n_run; m_level = n_level; m_left = n_left; m_tick = n_tick; m_valid = n_valid;
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_square", {31'b0, square_out}, 32'd0);
    chk("rst_tick", {31'b0, half_tick}, 32'd0);
    chk("rst_valid", {31'b0, sample_valid}, 32'd0);
    chk("rst_sample", {16'b0, sample_out}, 32'd0);
    m_run = 0; m_level = 0; m_left = 0; m_tick = 0; m_valid = 0;
    exp_q.delete();
  endtask

  // Monitor: compare every cycle against the model and pop on each strobe.
  always @(negedge clk) begin
    logic [15:0] e;
    chk("square_out", {31'b0, square_out}, {31'b0, m_level});
    chk("half_tick", {31'b0, half_tick}, {31'b0, m_tick});
    chk("sample_valid", {31'b0, sample_valid}, {31'b0, m_valid});
    if (sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sample_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sample_out", {16'b0, sample_out}, {16'b0, e});
      end
    end
  end

  initial begin
    logic [31:0] div;
    logic        en;
    // 1: reset with divisor 8, then free run
    #2;
    chk("init_square", {31'b0, square_out}, 32'd0);
    chk("init_valid", {31'b0, sample_valid}, 32'd0);
    @(posedge clk); #1;
    tick(1, 8, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) tick(1, 8, 0);
    // 2: divisor change mid half-period
    tick(1, 8, 0);
    for (int i = 0; i < 36; i++) tick(1, 12, 0);
    // 3: odd divisor, then silence via divisor 1 and 0
    for (int i = 0; i < 20; i++) tick(1, 9, 0);
    for (int i = 0; i < 4; i++) tick(1, 1, i[0]);
    for (int i = 0; i < 4; i++) tick(1, 0, 1);
    // 4: sample pulses at both levels, then held request
    for (int i = 0; i < 20; i++) tick(1, 8, (i % 3) == 0);
    for (int i = 0; i < 3; i++) tick(1, 8, 1);
    for (int i = 0; i < 5; i++) tick(1, 8, 0);
    // 5: enable drop with simultaneous request, then re-enable
    tick(0, 8, 1);
    tick(0, 8, 1);
    for (int i = 0; i < 12; i++) tick(1, 8, 0);
    tick(1, 6, 1);
    tick(0, 6, 0);
    for (int i = 0; i < 8; i++) tick(1, 6, 1);
    // randomized section
    div = 32'd10; en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) div = 32'($urandom_range(0, 21));
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
        tick(en, div, 1'b0);
        rst_n = 1'b1;
      end
      tick(en, div, $urandom_range(0, 2) == 0);
    end
    // 6: realistic note with reset mid-period
    for (int i = 0; i < 30000; i++) tick(1, DO1, $urandom_range(0, 999) == 0);
    async_reset();
    tick(1, DO1, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 48000; i++) tick(1, DO1, $urandom_range(0, 999) == 0);
    tick(0, DO1, 0);
    tick(0, DO1, 0);
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Downstream stage of the note decoder. Consumes its 32-bit clock-divisor word, which is the number of 50 MHz cycles in one full tone period; 0 means no sound.
- Produces a 50%-duty square wave plus signed PCM samples, delivered to the audio-codec interface through a request/valid handshake.
- Switches pitch glitch-free at half-period boundaries, so note changes made from the switches do not click.

Parameters:
- DIV_W, 32, width of divisor input.
- SAMPLE_W, 16, width of signed PCM sample.
- AMPLITUDE, 16'sh2000, magnitude of the high/low sample level (must be positive).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- divisor  in  DIV_W  full-period cycle count from the note decoder; value < 2 means silence.
- enable  in  1  mute control; 0 forces silence.
- sample_req  in  1  one-cycle pulse from the codec requesting the next sample.
- sample_out  out  SAMPLE_W  signed PCM sample.
- sample_valid  out  1  one-cycle strobe marking sample_out as valid.
- square_out  out  1  square wave (for a GPIO/LED).
- half_tick  out  1  one-cycle pulse at every square_out toggle.

Behaviour:
- Reset (async, rst_n=0): state=SILENT; counter=0; active_half=0; square_out=0; half_tick=0; sample_out=0; sample_valid=0.
- Definition: half = divisor >> 1, a logical shift, so odd divisors round down.
- State SILENT:
  - square_out held 0; counter held 0.
  - On a cycle with enable=1 and divisor>=2: latch active_half=half, counter=0, square_out=1, go to RUN. Transition takes 1 cycle and half_tick is not pulsed.
- State RUN:
  - counter increments each cycle.
  - When counter==active_half-1: counter<=0, square_out toggles, half_tick=1 for that cycle, and active_half<=half, sampled in that same cycle.
  - A divisor change therefore takes effect only at the next toggle, never mid half-period.
- RUN exit: at any cycle with enable=0 or divisor<2, go to SILENT immediately. On the next edge square_out=0 and counter=0.
- Full-period length in RUN = 2*active_half cycles.
- Counter width = DIV_W; no overflow is possible because counter < active_half.
- Sample handshake:
  - On sample_req=1, register sample_out on the next edge and pulse sample_valid high for exactly 1 cycle. Latency is 1 cycle.
  - sample_out = +AMPLITUDE if RUN and square_out=1; −AMPLITUDE if RUN and square_out=0; 0 if SILENT.
  - The value is based on the state and square_out present in the request cycle.
- Back-to-back requests: sample_req high on consecutive cycles gives sample_valid high on consecutive cycles, each with the current sample. No queueing.
- Between strobes, sample_out holds its last value.
- sample_req in the same cycle as a toggle: the sample uses the pre-toggle square_out.
- sample_req in the same cycle as the RUN→SILENT decision: the sample uses RUN/pre-exit values.
- Reset mid-operation: all outputs return to reset values asynchronously. No pending request survives reset.

Decomposition:
- Shared package (audio_pkg):
  - State encoding: SILENT=1'b0, RUN=1'b1.
  - CLK_HZ=50_000_000.
  - Default AMPLITUDE.
  - Note divisor constants (DO1..DO2 = CLK_HZ/523..CLK_HZ/1046), so the decoder and benches share one source.
- One natural sub-module, half_period_counter: counter, active_half reload and half_tick generation.
- tone_gen keeps the FSM, square_out and the sample handshake.

Test Plan:
1. Reset with divisor=8, enable=1; release rst_n -> after 1 cycle RUN, square_out=1; square_out toggles every 4 cycles with half_tick pulses; full period 8 cycles.
2. divisor changed 8→12 mid half-period -> the current half-period still lasts 4 cycles, later half-periods last 6 cycles; no short or long pulse.
3. divisor=9 -> half=4; period 8 cycles. divisor=1 or 0 -> SILENT next edge, square_out=0; sample_req gives sample_out=0, sample_valid one cycle after.
4. RUN with square_out=1, sample_req pulse -> next cycle sample_valid=1, sample_out=16'sh2000. With square_out=0 -> 16'shE000. sample_req held 3 cycles -> 3 consecutive valid strobes.
5. enable dropped mid-RUN, plus sample_req in the same cycle -> sample reflects the pre-exit level; next cycle square_out=0, counter=0. Re-enable restarts with square_out=1.
6. Realistic run: divisor=95602 (DO1), rst_n asserted at cycle 30000 mid-period -> all outputs 0 immediately. After release, 47801 cycles per half-period.
